// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the FIFO burst reader.
package fifo_reader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the reader.
interface fifo_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  // Reader side: consumes the FIFO, produces the stream.
  modport master (
    input  fifo_empty, fifo_data_out, m_ready,
    output fifo_rd_en, m_data, m_valid
  );

  // Environment side: the FIFO and the downstream consumer.
  modport slave (
    output fifo_empty, fifo_data_out, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry first-in-first-out output buffer; slot0 always holds the oldest word.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            occupancy,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  assign data = slot0;

  // Shift-on-pop storage; push lands behind whatever is still held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy <= 2'd0;
      // NOTE: the data slots are reset too so the stream data reads 0 after reset, not stale words.
      slot0     <= '0;
      slot1     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every slot update sees the pre-edge values.
      unique case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) slot0 <= din;
          else                   slot1 <= din;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          slot0     <= slot1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the oldest leaves while the newest joins the tail.
          if (occupancy == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls a counted (or drain-until-empty) burst from a FIFO into a stream.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  fifo_reader_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_read
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] READ  = ST_READ;
  localparam logic [1:0] FLUSH = ST_FLUSH;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             drain;
  logic             inflight;
  logic [1:0]       occupancy;
  logic [1:0]       level;
  logic             pop;
  logic             rd_en;

  assign pop            = bus.m_valid & bus.m_ready;
  assign bus.m_valid    = (occupancy != 2'd0);
  assign bus.fifo_rd_en = rd_en;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  // Read qualification: the buffer plus the word in flight must leave room for one more.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    level = 2'd0;
    rd_en = 1'b0;
    // A word leaving downstream this cycle frees its slot in time, which keeps one word per cycle.
    level = occupancy - {1'b0, pop} + {1'b0, inflight};
    rd_en = (state == READ) && !bus.fifo_empty &&
            (drain || remaining != '0) && (level < 2'd2);
  end

  // Burst FSM with remaining / words_read counters and the one-cycle in-flight flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      drain      <= 1'b0;
      words_read <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READ;
            remaining  <= burst_len;
            drain      <= (burst_len == '0);
            words_read <= '0;
          end
        end
        READ: begin
          if (rd_en) begin
            if (!drain) remaining <= remaining - 1'b1;
            words_read <= words_read + 1'b1;
          end
          if (( drain && bus.fifo_empty) ||
              (!drain && (remaining == '0 || (rd_en && remaining == LEN_W'(1)))))
            state <= FLUSH;
        end
        FLUSH: begin
          if (!inflight && occupancy == 2'd0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (pop),
    .din       (bus.fifo_data_out),
    .occupancy (occupancy),
    .data      (bus.m_data)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: FIFO model, stream monitor and step-by-step checks.
module tb_fifo_reader;

  localparam int DW = 8;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_read;

  fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .words_read (words_read)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read enable.
  logic [DW-1:0] mem [256];
  int wptr = 0;
  int rptr = 0;

  assign bus.fifo_empty = (rptr == wptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en && rptr != wptr) begin
      bus.fifo_data_out <= mem[rptr % 256];
      rptr <= rptr + 1;
    end
  end

  // Stream monitor, sampled mid-cycle.
  logic [DW-1:0] got [$];
  int rd_cnt = 0, xf_cnt = 0, done_cnt = 0, viol = 0;
  int cyc = 0, last_xfer = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      rd_cnt = 0;
      xf_cnt = 0;
    end else begin
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
      if (bus.fifo_rd_en && !busy) viol++;
      if (rd_cnt - xf_cnt > 2) viol++;
      if (bus.fifo_rd_en && (rd_cnt - xf_cnt) == 2 && !bus.m_ready) viol++;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        xf_cnt++;
        last_xfer = cyc;
      end
      if (bus.fifo_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wptr % 256] = d;
    wptr++;
  endtask

  task automatic start_burst(input logic [LW-1:0] len);
    tick();
    start = 1'b1;
    burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = done;
      if (!seen && toggle) begin
        @(posedge clk);
        #1;
        bus.m_ready = !bus.m_ready;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base, input logic [DW-1:0] first, input int n);
    check({tag, " count"}, 32'(got.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < got.size(); i++)
      check({tag, " word"}, 32'(got[base + i]), 32'(first + DW'(i)));
  endtask

  initial begin
    int gb, db, vb;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst rd_en",      32'(bus.fifo_rd_en), 32'd0);
    check("rst m_valid",    32'(bus.m_valid),    32'd0);
    check("rst busy",       32'(busy),           32'd0);
    check("rst done",       32'(done),           32'd0);
    check("rst words_read", 32'(words_read),     32'd0);
    check("rst m_data",     32'(bus.m_data),     32'd0);
    rst = 1'b1;
    tick();

    // Burst of 5 with m_ready held high: latency and sustained throughput
    for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
    gb = got.size(); db = done_cnt; vb = viol;
    start_burst(6'd5);
    @(negedge clk);
    check("t1 c1 rd_en",   32'(bus.fifo_rd_en), 32'd1);
    check("t1 c1 m_valid", 32'(bus.m_valid),    32'd0);
    check("t1 c1 busy",    32'(busy),           32'd1);
    @(negedge clk);
    check("t1 c2 m_valid", 32'(bus.m_valid),    32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1 m_valid", 32'(bus.m_valid), 32'd1);
      check("t1 m_data",  32'(bus.m_data),  32'h11 + 32'(i));
    end
    @(negedge clk);
    check("t1 c8 done", 32'(done), 32'd0);
    @(negedge clk);
    check("t1 c9 done", 32'(done), 32'd1);
    tick();
    check("t1 busy after",  32'(busy),       32'd0);
    check("t1 done after",  32'(done),       32'd0);
    check("t1 words_read",  32'(words_read), 32'd5);
    check_stream("t1", gb, 8'h11, 5);
    check("t1 done pulses", 32'(done_cnt - db), 32'd1);
    check("t1 protocol",    32'(viol - vb),     32'd0);

    // Same burst with m_ready toggling every cycle
    for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
    gb = got.size(); db = done_cnt; vb = viol;
    start_burst(6'd5);
    wait_done("t2", 200, 1'b1);
    tick(); tick();
    bus.m_ready = 1'b1;
    check_stream("t2", gb, 8'h11, 5);
    check("t2 words_read",  32'(words_read),    32'd5);
    check("t2 done pulses", 32'(done_cnt - db), 32'd1);
    check("t2 protocol",    32'(viol - vb),     32'd0);

    // Drain mode with 7 words queued
    for (int i = 0; i < 7; i++) push_word(8'h31 + 8'(i));
    gb = got.size(); db = done_cnt; vb = viol;
    start_burst(6'd0);
    wait_done("t3", 200, 1'b0);
    tick();
    check_stream("t3", gb, 8'h31, 7);
    check("t3 words_read",  32'(words_read),        32'd7);
    check("t3 done pulses", 32'(done_cnt - db),     32'd1);
    check("t3 done late",   32'(done_cyc > last_xfer), 32'd1);
    check("t3 fifo empty",  32'(bus.fifo_empty),    32'd1);
    check("t3 protocol",    32'(viol - vb),         32'd0);

    // Burst of 4 with only 2 available: stall, then resume
    push_word(8'h41); push_word(8'h42);
    gb = got.size(); db = done_cnt;
    start_burst(6'd4);
    repeat (20) tick();
    check("t4 stall count", 32'(got.size() - gb), 32'd2);
    check("t4 stall busy",  32'(busy),            32'd1);
    check("t4 stall wr",    32'(words_read),      32'd2);
    check("t4 stall done",  32'(done_cnt - db),   32'd0);
    push_word(8'h43); push_word(8'h44);
    wait_done("t4", 200, 1'b0);
    tick();
    check_stream("t4", gb, 8'h41, 4);
    check("t4 words_read", 32'(words_read), 32'd4);

    // Reset mid-burst after the third read
    for (int i = 0; i < 6; i++) push_word(8'h51 + 8'(i));
    db = done_cnt;
    start_burst(6'd6);
    tick(); tick();
    check("t5 pre wr",    32'(words_read),      32'd2);
    check("t5 pre rd_en", 32'(bus.fifo_rd_en),  32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5 rd_en",      32'(bus.fifo_rd_en), 32'd0);
    check("t5 m_valid",    32'(bus.m_valid),    32'd0);
    check("t5 busy",       32'(busy),           32'd0);
    check("t5 done",       32'(done),           32'd0);
    check("t5 words_read", 32'(words_read),     32'd0);
    check("t5 m_data",     32'(bus.m_data),     32'd0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("t5 no done", 32'(done_cnt - db), 32'd0);
    check("t5 idle",    32'(busy),          32'd0);
    gb = got.size(); db = done_cnt;
    start_burst(6'd0);
    wait_done("t5 restart", 200, 1'b0);
    tick();
    check_stream("t5", gb, 8'h54, 3);
    check("t5 restart wr", 32'(words_read), 32'd3);

    // start while busy is ignored
    for (int i = 0; i < 4; i++) push_word(8'h61 + 8'(i));
    gb = got.size();
    bus.m_ready = 1'b0;
    start_burst(6'd4);
    repeat (4) tick();
    check("t6 held wr", 32'(words_read), 32'd2);
    start = 1'b1;
    burst_len = 6'd9;
    tick();
    start = 1'b0;
    tick();
    check("t6 ignored wr",   32'(words_read), 32'd2);
    check("t6 ignored busy", 32'(busy),       32'd1);
    bus.m_ready = 1'b1;
    wait_done("t6", 200, 1'b0);
    tick();
    check_stream("t6", gb, 8'h61, 4);
    check("t6 words_read", 32'(words_read), 32'd4);
    repeat (3) tick();
    check("t6 wr holds",    32'(words_read),     32'd4);
    check("t6 fifo empty",  32'(bus.fifo_empty), 32'd1);
    check("all protocol",   32'(viol),           32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width matching the FIFO data_out.
REQ-002 The block SHALL have parameter LEN_W, default 6, burst-length width (max burst 2**LEN_W-1).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse, begins a read burst; ignored unless idle.
REQ-006 The block SHALL have port burst_len  input  LEN_W  words to read, sampled on accepted start; 0 means drain-until-empty.
REQ-007 The block SHALL have port fifo_empty  input  1  FIFO empty indicator.
REQ-008 The block SHALL have port fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 The block SHALL have port fifo_rd_en  output  1  FIFO read enable, one word per asserted cycle.
REQ-010 The block SHALL have port m_data  output  DATA_WIDTH  downstream stream data.
REQ-011 The block SHALL have port m_valid  output  1  m_data valid.
REQ-012 The block SHALL have port m_ready  input  1  downstream accept; transfer when m_valid and m_ready.
REQ-013 The block SHALL have port busy  output  1  high from accepted start until done.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse, burst complete and all words delivered.
REQ-015 The block SHALL have port words_read  output  LEN_W  count of FIFO reads issued in current/last burst.

Function
REQ-016 The block SHALL implement states IDLE, READ, FLUSH, DONE.
REQ-017 IDLE->READ on start; burst_len latched into remaining counter; words_read cleared to 0.
REQ-018 In READ, fifo_rd_en SHALL assert iff !fifo_empty, remaining!=0 (or drain mode), and buffer occupancy + in-flight read < 2.
REQ-019 Each issued read SHALL decrement remaining and increment words_read; in-flight flag set for exactly one cycle.
REQ-020 The word on fifo_data_out SHALL be captured into the 2-entry output buffer the cycle after fifo_rd_en, never dropped.
REQ-021 Output buffer SHALL be first-in-first-out; m_valid high whenever occupancy>0; m_data = oldest entry.
REQ-022 Simultaneous capture and downstream transfer SHALL leave occupancy unchanged with order preserved.
REQ-023 READ->FLUSH when remaining reaches 0, or in drain mode when fifo_empty is high with no read issued that cycle.
REQ-024 FLUSH->DONE when no read in flight and occupancy is 0; DONE asserts done for one cycle then ->IDLE.
REQ-025 fifo_empty high in non-drain mode SHALL stall READ indefinitely (no timeout, no error).
REQ-026 Minimum latency: start at cycle 0, non-empty FIFO, m_ready=1 -> fifo_rd_en cycle 1, m_valid cycle 3, one word/cycle sustained thereafter.
REQ-027 fifo_rd_en SHALL never assert in IDLE, FLUSH or DONE, and never when fifo_empty is high.
REQ-028 start while busy SHALL be ignored with no effect on counters.
REQ-029 words_read SHALL hold its final value after done until the next accepted start.

Reset
REQ-030 rst low on a rising edge SHALL force state IDLE, fifo_rd_en=0, m_valid=0, busy=0, done=0, words_read=0, occupancy=0, in-flight=0.
REQ-031 Reset mid-burst SHALL discard buffered and in-flight words; no done pulse.
REQ-032 m_data reset value SHALL be 0.

Structure
REQ-033 Package fifo_reader_pkg SHALL hold the state enum type and default DATA_WIDTH/LEN_W constants.
REQ-034 The 2-entry output buffer SHALL be sub-module fifo_reader_skid (push, pop, occupancy, data).
REQ-035 The top module SHALL contain only the FSM, counters and rd_en qualification.

Verification
REQ-036 FIFO preloaded 0x11..0x15, burst_len=5, m_ready=1 -> m_data 0x11..0x15 in order, words_read=5, single done pulse.
REQ-037 Same preload, m_ready toggled 1/0 each cycle -> no loss/duplication, occupancy never >2, fifo_rd_en stalls while buffer full.
REQ-038 burst_len=0, FIFO holds 7 words -> exactly 7 delivered, words_read=7, done after last transfer.
REQ-039 burst_len=4, FIFO holds 2 -> 2 delivered, busy stays high; 2 more written later -> 4 total, done.
REQ-040 rst low mid-burst after 3 reads -> next cycle all outputs at reset values, no done; new start works.
REQ-041 start pulsed while busy -> ignored, words_read and remaining unaffected.
